bus_mem_slave: RTL and testbench

Single-port word-organised memory that answers on the responder side of the core's master bus (bus enable, write enable, address, write data, byte enables / ack, read data). It latches one request at a time, waits a programmable number of cycles, commits writes under byte enables or captures read data, and returns a single-cycle acknowledge. It sits between the bus interface of a hart and its instruction/data storage and serves as the default memory model in single-core builds and benches.

---
 rtl/bus_mem_slave.sv | 134 +++++++++++++
 tb/tb_bus_mem_slave.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_slave.sv
// bus_mem_slave: word-organised memory on the responder side of the master bus.
// One request at a time, programmable latency, single-cycle registered ack.
module bus_mem_slave #(
  parameter int               XLEN      = 32,
  parameter int               MEM_WORDS = 1024,
  parameter logic [XLEN-1:0]  BASE_ADDR = '0,
  parameter int               LATENCY   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_bus_en,
  input  logic                i_wr_en,
  input  logic [XLEN-1:0]     i_addr,
  input  logic [XLEN-1:0]     i_wr_data,
  input  logic [XLEN/8-1:0]   i_byte_en,
  output logic                o_ack,
  output logic [XLEN-1:0]     o_rd_data
);

  localparam int NB = XLEN / 8;
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam logic [XLEN-3:0] NWORDS = (XLEN-2)'(MEM_WORDS);
  localparam logic [XLEN-3:0] BASE_W = BASE_ADDR[XLEN-1:2];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [NB-1:0]     be_q;
  logic [XLEN-1:0]   rd_q;

  logic              accept;
  logic              enter_ack;
  logic              cur_wr;
  logic [XLEN-1:0]   cur_addr;
  logic [XLEN-1:0]   cur_wdata;
  logic [NB-1:0]     cur_be;
  logic [XLEN-3:0]   off_w;
  logic              in_range;
  logic [AW-1:0]     idx;

  logic [XLEN-1:0]   mem_q [MEM_WORDS];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_bus_en) begin
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? ACK : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ack     = (state_q == ACK);
    o_rd_data = rd_q;
  end

  // With LATENCY=1 the request completes on its own acceptance edge,
  // so the live bus fields are used instead of the latched copy.
  assign accept    = (state_q == IDLE) && i_bus_en;
  assign enter_ack = (state_d == ACK) && (state_q != ACK);
  assign cur_wr    = (state_q == IDLE) ? i_wr_en   : wr_q;
  assign cur_addr  = (state_q == IDLE) ? i_addr    : addr_q;
  assign cur_wdata = (state_q == IDLE) ? i_wr_data : wdata_q;
  assign cur_be    = (state_q == IDLE) ? i_byte_en : be_q;

  assign off_w    = cur_addr[XLEN-1:2] - BASE_W;
  assign in_range = (cur_addr >= BASE_ADDR) && (off_w < NWORDS);
  assign idx      = off_w[AW-1:0];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      wr_q    <= i_wr_en;
      addr_q  <= i_addr;
      wdata_q <= i_wr_data;
      be_q    <= i_byte_en;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_q <= '0;
    end else if (enter_ack && !cur_wr) begin
      rd_q <= in_range ? mem_q[idx] : '0;
    end
  end

  // Storage is not reset; i_rst gates the commit so reset drops writes.
  always_ff @(posedge i_clk) begin
    if (i_rst && enter_ack && cur_wr && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (cur_be[b]) begin
          mem_q[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_mem_slave.sv
// tb_bus_mem_slave: three configurations driven by directed and random
// transfers, checked against a sparse word-array reference model.
module tb_bus_mem_slave;

  localparam int NDUT  = 3;
  localparam int WORDS = 1024;
  localparam int LATS [NDUT] = '{1, 4, 8};
  localparam logic [31:0] BASES [NDUT] =
    '{32'h0, 32'h1000, 32'h0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_en [NDUT];
  logic        wr_en  [NDUT];
  logic [31:0] addr   [NDUT];
  logic [31:0] wdata  [NDUT];
  logic [3:0]  be     [NDUT];
  logic        ack    [NDUT];
  logic [31:0] rd     [NDUT];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_ack [NDUT];
  bit [31:0] mdl [int];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bus_mem_slave #(
    .XLEN(32), .MEM_WORDS(WORDS),
    .BASE_ADDR(32'h0), .LATENCY(1)
  ) u_d0 (
    .i_clk(clk), .i_rst(rst_n),
    .i_bus_en(bus_en[0]), .i_wr_en(wr_en[0]),
    .i_addr(addr[0]), .i_wr_data(wdata[0]),
    .i_byte_en(be[0]),
    .o_ack(ack[0]), .o_rd_data(rd[0])
  );

  bus_mem_slave #(
    .XLEN(32), .MEM_WORDS(WORDS),
    .BASE_ADDR(32'h1000), .LATENCY(4)
  ) u_d1 (
    .i_clk(clk), .i_rst(rst_n),
    .i_bus_en(bus_en[1]), .i_wr_en(wr_en[1]),
    .i_addr(addr[1]), .i_wr_data(wdata[1]),
    .i_byte_en(be[1]),
    .o_ack(ack[1]), .o_rd_data(rd[1])
  );

  bus_mem_slave #(
    .XLEN(32), .MEM_WORDS(WORDS),
    .BASE_ADDR(32'h0), .LATENCY(8)
  ) u_d2 (
    .i_clk(clk), .i_rst(rst_n),
    .i_bus_en(bus_en[2]), .i_wr_en(wr_en[2]),
    .i_addr(addr[2]), .i_wr_data(wdata[2]),
    .i_byte_en(be[2]),
    .o_ack(ack[2]), .o_rd_data(rd[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Applies one transfer to the model; returns expected read data.
  function automatic bit [31:0] model(input int d, input bit w,
                                      input logic [31:0] a,
                                      input logic [31:0] dat,
                                      input logic [3:0] b);
    longint off;
    int key;
    bit [31:0] word;
    off = longint'({a[31:2], 2'b00}) - longint'(BASES[d]);
    if (off < 0 || off >= 4 * WORDS) return 32'h0;
    key = d * 4096 + int'(off / 4);
    word = mdl.exists(key) ? mdl[key] : 32'h0;
    if (!w) return word;
    for (int i = 0; i < 4; i++)
      if (b[i]) word[8*i +: 8] = dat[8*i +: 8];
    mdl[key] = word;
    return 32'h0;
  endfunction

  task automatic xfer(input int d, input bit w,
                      input logic [31:0] a,
                      input logic [31:0] dat,
                      input logic [3:0] b,
                      input bit hold);
    bit [31:0] exp;
    int n;
    bus_en[d] = 1'b1;
    wr_en[d]  = w;
    addr[d]   = a;
    wdata[d]  = dat;
    be[d]     = b;
    exp = model(d, w, a, dat, b);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!ack[d] && n < 40);
    chk($sformatf("ack_lat%0d", d), n, LATS[d]);
    if (!w) chk($sformatf("rdata%0d", d), rd[d], exp);
    last_ack[d] = cyc;
    if (!hold) bus_en[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("ack_1cyc%0d", d), ack[d], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pool [16];
    logic [31:0] a;
    int t0;
    int sel;
    bit hold;

    for (int d = 0; d < NDUT; d++) begin
      bus_en[d] = 1'b0;
      wr_en[d]  = 1'b0;
      addr[d]   = '0;
      wdata[d]  = '0;
      be[d]     = '0;
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("idle_ack%0d", d), ack[d], 0);
        chk($sformatf("idle_rd%0d", d), rd[d], 0);
      end
    end

    // Full write/read and byte-lane merge at LATENCY=1.
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 0);
    chk("rd_deadbeef", rd[0], 32'hDEADBEEF);
    xfer(0, 1, 32'h20, 32'h11223344, 4'hF, 0);
    xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    xfer(0, 1, 32'h20, 32'h55555555, 4'h0, 0);
    xfer(0, 0, 32'h20, 32'h0, 4'h0, 0);
    chk("rd_merge", rd[0], 32'h11BB33DD);
    xfer(0, 1, 32'h24, 32'h99999999, 4'hF, 0);
    chk("rd_hold_on_wr", rd[0], 32'h11BB33DD);

    // Out-of-range with BASE_ADDR=0x1000, then back-to-back at LATENCY=4.
    xfer(1, 1, 32'h1000, 32'hCAFEF00D, 4'hF, 0);
    xfer(1, 1, 32'h1004, 32'h01020304, 4'hF, 0);
    xfer(1, 1, 32'h1008, 32'hA5A5A5A5, 4'hF, 0);
    xfer(1, 1, 32'h0FFC, 32'hFFFFFFFF, 4'hF, 0);
    xfer(1, 0, 32'h0FFC, 32'h0, 4'h0, 0);
    chk("oor_lo_rd", rd[1], 32'h0);
    xfer(1, 0, 32'h2000, 32'h0, 4'h0, 0);
    chk("oor_hi_rd", rd[1], 32'h0);
    xfer(1, 0, 32'h1000, 32'h0, 4'hF, 1);
    chk("oor_intact", rd[1], 32'hCAFEF00D);
    t0 = last_ack[1];
    xfer(1, 0, 32'h1004, 32'h0, 4'h0, 1);
    chk("b2b_gap1", last_ack[1] - t0, 5);
    t0 = last_ack[1];
    xfer(1, 0, 32'h1008, 32'h0, 4'h0, 0);
    chk("b2b_gap2", last_ack[1] - t0, 5);
    chk("b2b_rd", rd[1], 32'hA5A5A5A5);

    // Reset while a LATENCY=8 write is pending.
    xfer(2, 1, 32'h40, 32'h0, 4'hF, 0);
    bus_en[2] = 1'b1;
    wr_en[2]  = 1'b1;
    addr[2]   = 32'h40;
    wdata[2]  = 32'h12345678;
    be[2]     = 4'hF;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus_en[2] = 1'b0;
    chk("rst_ack_now", ack[2], 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_ack", ack[2], 0);
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_ack", ack[2], 0);
    end
    chk("post_rst_rd", rd[2], 32'h0);
    xfer(2, 0, 32'h40, 32'h0, 4'h0, 0);
    chk("rst_dropped_wr", rd[2], 32'h0);

    // Randomised traffic against the model.
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 16; k++) begin
        pool[k] = (k < 12) ? BASES[d] + 32'(4 * k)
                           : BASES[d] + 32'(4 * (WORDS - 16 + k));
        xfer(d, 1, pool[k], $urandom, 4'hF, 0);
      end
      for (int i = 0; i < 50; i++) begin
        sel = int'($urandom % 8);
        if (sel == 0)      a = BASES[d] + 32'(4 * WORDS);
        else if (sel == 1) a = BASES[d] - 32'd4;
        else               a = pool[$urandom % 16];
        a[1:0] = 2'($urandom % 4);
        hold = (i != 49) && ($urandom % 2 == 1);
        xfer(d, 1'($urandom % 2), a, $urandom,
             4'($urandom % 16), hold);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
